imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Runtime program loader for the single-cycle MIPS core.
- Accepts a byte stream on a valid/ready interface and assembles big-endian 32-bit instruction words.
- Writes those words into instruction memory at consecutive word addresses.
- Holds the processor in reset (`cpu_hold`) until a load completes with a correct checksum. This replaces hierarchical preloading of instruction memory.

Parameters:
- ADDR_W, 6, imem word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising clk edge.
- restart  input  1  single-cycle pulse; honoured only in DONE or ERROR.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  processor reset request, active-high.
- load_done  output  1  load finished, checksum matched.
- load_err  output  1  load aborted.

Behaviour:
- Reset is asynchronous, active-low, and affects only loader state; imem contents are not touched.
- Reset values:
  - state = CNT_HI
  - in_ready = 1
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - cpu_hold = 1
  - load_done = 0, load_err = 0
  - internal byte index, word counter and checksum = 0
- Frame format:
  - count_hi, count_lo: 16-bit word count N, big-endian.
  - N×4 payload bytes, each word MSB first.
  - 1 checksum byte = XOR of all payload bytes only (count bytes excluded).
- States and transitions; each transition happens on an accepted byte unless stated otherwise:
  - CNT_HI: latch the high count byte → CNT_LO.
  - CNT_LO: latch the low count byte.
    - N > 2^ADDR_W → ERROR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA:
    - Shift the byte into a 32-bit assembly register (first byte lands in [31:24]).
    - XOR the byte into the checksum.
    - On the 4th byte of a word:
      - Next cycle: imem_we = 1 for exactly one cycle, imem_wdata = the assembled word, imem_addr = the current word index.
      - The word index increments after the write.
    - After word N's 4th byte → CSUM.
  - CSUM: compare the received byte with the running checksum. Equal → DONE; different → ERROR.
  - DONE: in_ready = 0, cpu_hold = 0, load_done = 1.
  - ERROR: in_ready = 0, cpu_hold = 1, load_err = 1.
- Restart: a restart pulse in DONE or ERROR returns to CNT_HI next cycle.
  - Clears the word index and checksum.
  - Sets cpu_hold = 1, load_done = 0, load_err = 0, in_ready = 1.
  - restart in any other state is ignored.
- in_ready is 1 in CNT_HI, CNT_LO, DATA and CSUM, so one byte per cycle is sustainable at full rate. A de-asserted in_valid simply stalls the loader; no timeout.
- imem_we write latency: exactly 1 cycle after the 4th byte of a word is accepted. Back-to-back words give write pulses 4 cycles apart.
- Words already written before an ERROR remain in imem, and cpu_hold stays 1.
- Word index arithmetic is ADDR_W bits. N == 2^ADDR_W exactly is legal; the last write is at address 2^ADDR_W−1 with no wrap.
- An asynchronous reset mid-frame discards the partial word and returns to CNT_HI with cpu_hold = 1.
- load_done and load_err are never both 1.

Test Plan:
- Nominal load:
  - Stimulus: bytes 00 03 20 08 00 00 21 08 00 01 11 08 FF FE 18, streamed back-to-back.
  - Required: exactly 3 imem_we pulses (addr 0 = 0x20080000, addr 1 = 0x21080001, addr 2 = 0x1108FFFE), then load_done = 1, cpu_hold = 0, in_ready = 0.
- Bad checksum:
  - Stimulus: the same frame with a final byte of 0x19.
  - Required: 3 writes still occur, then load_err = 1, cpu_hold = 1, load_done = 0.
- Oversize and empty counts (ADDR_W = 6):
  - Count 00 41 → ERROR immediately after the 2nd byte, no imem_we.
  - Count 00 00 followed by checksum 00 → DONE with no writes.
- Stalls:
  - Stimulus: the nominal frame with in_valid toggled 1-0-0-1.
  - Required: identical write contents and addresses as the nominal load; no byte is lost or duplicated.
- Restart:
  - Stimulus: from DONE, a restart pulse, then frame 00 01 AA BB CC DD 00.
  - Required: cpu_hold returns to 1; addr 0 = 0xAABBCCDD; load_done = 1 again. (Checksum: AA^BB^CC^DD = 0x00.)
- Reset mid-frame:
  - Stimulus: rst_n pulled low after 6 payload bytes of the nominal frame, then the full nominal frame resent.
  - Required: immediately on reset, outputs take their reset values. After the resend, the nominal result holds with writes starting at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: runtime program loader for the single-cycle MIPS core.
// It takes a byte stream (valid/ready), assembles big-endian 32-bit words,
// writes them to instruction memory at consecutive word addresses, and keeps
// the CPU in reset until a frame finishes with a matching checksum.
//
// Frame: count_hi, count_lo, N*4 payload bytes (MSB first), XOR checksum byte.
//
// Ports:
//   clk, rst_n      system clock (rising edge), async active-low reset
//   in_valid/in_data/in_ready   byte stream handshake
//   restart         pulse; only acts in DONE or ERROR
//   imem_we/imem_addr/imem_wdata   one-cycle word write to instruction memory
//   cpu_hold        processor reset request (active high)
//   load_done       frame loaded, checksum good
//   load_err        frame aborted (oversize count or bad checksum)
//
// state    | meaning
// ---------+-------------------------------------------------
// S_CNT_HI | waiting for high byte of word count
// S_CNT_LO | waiting for low byte; range-check the count
// S_DATA   | receiving payload bytes, writing each full word
// S_CSUM   | waiting for checksum byte
// S_DONE   | load good, CPU released
// S_ERROR  | load aborted, CPU held

module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state, state_nxt;
  logic [7:0]        cnt_hi;
  logic [15:0]       count_n;
  logic [ADDR_W:0]   words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [7:0]        csum;
  logic [23:0]       asm_word;

  assign count_n = {cnt_hi, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CNT_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CNT_LO;
      end
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ({1'b0, count_n} > MAX_WORDS) state_nxt = S_ERROR;
          else if (count_n == 16'd0)       state_nxt = S_CSUM;
          else                             state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        // words_left counts down; last byte of the last word ends payload
        if (in_valid && byte_idx == 2'd3 && words_left == (ADDR_W+1)'(1))
          state_nxt = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (restart) state_nxt = S_CNT_HI;
      end
      S_ERROR: begin
        load_err = 1'b1;
        if (restart) state_nxt = S_CNT_HI;
      end
      default: state_nxt = S_CNT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cnt_hi     <= '0;
      words_left <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      asm_word   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_CNT_HI: if (in_valid) cnt_hi <= in_data;
        // an out-of-range count goes to ERROR, so truncation here is harmless
        S_CNT_LO: if (in_valid) words_left <= count_n[ADDR_W:0];
        S_DATA: begin
          if (in_valid) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            asm_word <= {asm_word[15:0], in_data};
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {asm_word, in_data};
              imem_addr  <= word_idx;
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole-frame vectors plus
// hand-written sequences for restart, mid-frame reset and a full-capacity load.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor, sampled mid-cycle
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  int                wr_cyc  [$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;     // left-justified, byte 0 in [127:120]
    logic [15:0]  stall;     // bit k: two idle cycles before byte k
    logic         exp_done;
    logic         exp_err;
    logic         exp_hold;
    logic         exp_ready;
    int           exp_nwr;
    logic [95:0]  exp_w;     // {word0, word1, word2}
  } vec_t;

  localparam int NV = 5;
  vec_t vec [NV];

  int total = 0;
  int passed = 0;
  int cyc0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic setv(input int i, input string name, input int nb, input logic [127:0] b,
                      input logic [15:0] st, input logic d, input logic e, input logic h,
                      input logic r, input int nwr, input logic [95:0] w);
    vec[i].name = name;  vec[i].nb = nb;  vec[i].bytes = b;  vec[i].stall = st;
    vec[i].exp_done = d; vec[i].exp_err = e; vec[i].exp_hold = h; vec[i].exp_ready = r;
    vec[i].exp_nwr = nwr; vec[i].exp_w = w;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    restart  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic send_vec(input int i);
    for (int k = 0; k < vec[i].nb; k++) begin
      if (vec[i].stall[k]) begin
        idle_cycle();
        idle_cycle();
      end
      send_byte(vec[i].bytes[127-8*k -: 8]);
      if (k == 0) cyc0 = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int nwr, input logic [95:0] w);
    chk({tag, "/nwr"}, 32'(wr_addr.size()), 32'(nwr));
    for (int k = 0; k < nwr; k++) begin
      if (k < wr_addr.size()) begin
        chk($sformatf("%s/addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
        chk($sformatf("%s/data%0d", tag, k), wr_data[k], w[95-32*k -: 32]);
      end
    end
  endtask

  logic [95:0] nom_w;

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    rst_n    = 1'b0;
    nom_w    = {32'h20080000, 32'h21080001, 32'h1108FFFE};

    setv(0, "nominal", 15, {120'h000320080000210800011108FFFE18, 8'h00}, 16'h0000,
         1'b1, 1'b0, 1'b0, 1'b0, 3, nom_w);
    setv(1, "badcsum", 15, {120'h000320080000210800011108FFFE19, 8'h00}, 16'h0000,
         1'b0, 1'b1, 1'b1, 1'b0, 3, nom_w);
    setv(2, "oversize", 2, {16'h0041, 112'h0}, 16'h0000,
         1'b0, 1'b1, 1'b1, 1'b0, 0, 96'h0);
    setv(3, "empty", 3, {24'h000000, 104'h0}, 16'h0000,
         1'b1, 1'b0, 1'b0, 1'b0, 0, 96'h0);
    setv(4, "stall", 15, {120'h000320080000210800011108FFFE18, 8'h00}, 16'h4494,
         1'b1, 1'b0, 1'b0, 1'b0, 3, nom_w);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      send_vec(i);
      idle_cycle();
      idle_cycle();
      chk({vec[i].name, "/done"},  32'(load_done), 32'(vec[i].exp_done));
      chk({vec[i].name, "/err"},   32'(load_err),  32'(vec[i].exp_err));
      chk({vec[i].name, "/hold"},  32'(cpu_hold),  32'(vec[i].exp_hold));
      chk({vec[i].name, "/ready"}, 32'(in_ready),  32'(vec[i].exp_ready));
      check_writes(vec[i].name, vec[i].exp_nwr, vec[i].exp_w);
      if (i == 0 && wr_cyc.size() == 3) begin
        // 4th payload byte is frame byte 5; write is visible the cycle after it
        chk("nominal/lat0", 32'(wr_cyc[0]), 32'(cyc0 + 5));
        chk("nominal/gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        chk("nominal/gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
      end
    end

    // restart from DONE; a restart pulse while in CNT_LO must be ignored
    do_reset();
    send_vec(0);
    idle_cycle();
    chk("rst/pre_done", 32'(load_done), 32'd1);
    pulse_restart();
    chk("rst/hold",  32'(cpu_hold),  32'd1);
    chk("rst/done",  32'(load_done), 32'd0);
    chk("rst/err",   32'(load_err),  32'd0);
    chk("rst/ready", 32'(in_ready),  32'd1);
    clear_mon();
    send_byte(8'h00);
    in_valid = 1'b0;
    pulse_restart();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'h00);
    idle_cycle();
    idle_cycle();
    check_writes("rst", 1, {32'hAABBCCDD, 64'h0});
    chk("rst/done2", 32'(load_done), 32'd1);
    chk("rst/hold2", 32'(cpu_hold),  32'd0);

    // async reset after 6 payload bytes, then full resend
    do_reset();
    for (int k = 0; k < 8; k++) send_byte(vec[0].bytes[127-8*k -: 8]);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid/ready", 32'(in_ready),   32'd1);
    chk("mid/we",    32'(imem_we),    32'd0);
    chk("mid/addr",  32'(imem_addr),  32'd0);
    chk("mid/wdata", imem_wdata,      32'd0);
    chk("mid/hold",  32'(cpu_hold),   32'd1);
    chk("mid/done",  32'(load_done),  32'd0);
    chk("mid/err",   32'(load_err),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    send_vec(0);
    idle_cycle();
    idle_cycle();
    check_writes("mid", 3, nom_w);
    chk("mid/done2", 32'(load_done), 32'd1);

    // full capacity: 64 words, word w = 0x000000ww; XOR of 0..63 is 0
    do_reset();
    send_byte(8'h00);
    send_byte(8'h40);
    for (int w = 0; w < 64; w++) begin
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'(w));
    end
    send_byte(8'h00);
    idle_cycle();
    idle_cycle();
    chk("full/nwr", 32'(wr_addr.size()), 32'd64);
    for (int w = 0; w < 64; w++) begin
      if (w < wr_addr.size()) begin
        chk($sformatf("full/addr%0d", w), 32'(wr_addr[w]), 32'(w));
        chk($sformatf("full/data%0d", w), wr_data[w], 32'(w));
      end
    end
    chk("full/done", 32'(load_done), 32'd1);
    chk("full/err",  32'(load_err),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
